// File: rtl/riscv_pkg.sv
// Shared core definitions: writeback select encodings, load funct3 codes,
// writeback FSM states and the commit-write qualifier.
package riscv_pkg;

   typedef enum logic [1:0] {
      WB_NONE = 2'b00,
      WB_ALU  = 2'b01,
      WB_LOAD = 2'b10,
      WB_PC4  = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_LOAD = 2'b01,
      ST_COMMIT    = 2'b10
   } wb_state_e;

   // x0 is hardwired to zero, so a write to it is never issued.
   function automatic logic wb_writes(input wb_sel_e sel, input logic rd_nonzero,
                                      input logic fault);
      return (sel != WB_NONE) && rd_nonzero && !fault;
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute / data-memory / register-file bundle seen by the writeback stage.
// WB_FWD_EN adds the decode bypass signals fwd_valid/fwd_rd/fwd_data.
interface wb_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) ();

   logic            ex_valid;
   logic            ex_ready;
   logic [RA_W-1:0] ex_rd;
   logic [1:0]      ex_wb_sel;
   logic [XLEN-1:0] ex_alu_result;
   logic [XLEN-1:0] ex_pc_plus4;
   logic [2:0]      ex_funct3;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic [RA_W-1:0] rf_addr_rd;
   logic [XLEN-1:0] rf_data_rd;
   logic            rf_write_enable;
   logic            wb_done;
   logic            wb_fault;
`ifdef WB_FWD_EN
   logic            fwd_valid;
   logic [RA_W-1:0] fwd_rd;
   logic [XLEN-1:0] fwd_data;

   modport master (
      output ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_funct3,
      output mem_rvalid, mem_rdata,
      input  ex_ready, rf_addr_rd, rf_data_rd, rf_write_enable, wb_done, wb_fault,
      input  fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_funct3,
      input  mem_rvalid, mem_rdata,
      output ex_ready, rf_addr_rd, rf_data_rd, rf_write_enable, wb_done, wb_fault,
      output fwd_valid, fwd_rd, fwd_data
   );
`else
   modport master (
      output ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_funct3,
      output mem_rvalid, mem_rdata,
      input  ex_ready, rf_addr_rd, rf_data_rd, rf_write_enable, wb_done, wb_fault
   );

   modport slave (
      input  ex_valid, ex_rd, ex_wb_sel, ex_alu_result, ex_pc_plus4, ex_funct3,
      input  mem_rvalid, mem_rdata,
      output ex_ready, rf_addr_rd, rf_data_rd, rf_write_enable, wb_done, wb_fault
   );
`endif

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment and extension from an aligned memory word; flags
// misaligned halfword/word accesses and unsupported load funct3 codes.
module load_align
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   output logic [XLEN-1:0] data,
   output logic            fault
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(rdata >> {addr_lo, 3'b000});
      half_sel = 16'(rdata >> {addr_lo, 3'b000});
      data     = '0;
      fault    = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH: begin
            if (addr_lo == 2'd3) fault = 1'b1;
            else                 data  = {{(XLEN-16){half_sel[15]}}, half_sel};
         end
         F3_LHU: begin
            if (addr_lo == 2'd3) fault = 1'b1;
            else                 data  = {{(XLEN-16){1'b0}}, half_sel};
         end
         F3_LW: begin
            if (addr_lo != 2'd0) fault = 1'b1;
            else                 data  = rdata;
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one registered register-file write per retiring instruction.
// Define WB_FWD_EN to expose the fwd_valid/fwd_rd/fwd_data decode bypass.
module wb_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   wb_stage_if.slave wb
);

   wb_state_e       state_q, state_d;
   logic [RA_W-1:0] rd_q, rd_d;
   wb_sel_e         sel_q, sel_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lo_q, lo_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] al_data;
   logic            al_fault;

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata   (wb.mem_rdata),
      .funct3  (f3_q),
      .addr_lo (lo_q),
      .data    (al_data),
      .fault   (al_fault)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= '0;
         sel_q   <= WB_NONE;
         f3_q    <= '0;
         lo_q    <= '0;
         data_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         sel_q   <= sel_d;
         f3_q    <= f3_d;
         lo_q    <= lo_d;
         data_q  <= data_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      sel_d   = sel_q;
      f3_d    = f3_q;
      lo_d    = lo_q;
      data_d  = data_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (wb.ex_valid) begin
               rd_d    = wb.ex_rd;
               sel_d   = wb_sel_e'(wb.ex_wb_sel);
               f3_d    = wb.ex_funct3;
               lo_d    = wb.ex_alu_result[1:0];
               fault_d = 1'b0;
               case (wb_sel_e'(wb.ex_wb_sel))
                  WB_LOAD: begin
                     data_d  = '0;
                     state_d = ST_WAIT_LOAD;
                  end
                  WB_ALU: begin
                     data_d  = wb.ex_alu_result;
                     state_d = ST_COMMIT;
                  end
                  WB_PC4: begin
                     data_d  = wb.ex_pc_plus4;
                     state_d = ST_COMMIT;
                  end
                  default: begin
                     data_d  = '0;
                     state_d = ST_COMMIT;
                  end
               endcase
            end
         end
         ST_WAIT_LOAD: begin
            // Alignment uses the funct3/addr_lo latched at accept time.
            if (wb.mem_rvalid) begin
               data_d  = al_data;
               fault_d = al_fault;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   logic            commit;
   logic            wr_en;
   logic [RA_W-1:0] wr_addr;
   logic [XLEN-1:0] wr_data;

   assign commit  = (state_q == ST_COMMIT);
   assign wr_en   = commit && wb_writes(sel_q, |rd_q, fault_q);
   assign wr_addr = commit ? rd_q : '0;
   assign wr_data = (commit && !fault_q) ? data_q : '0;

   assign wb.ex_ready        = (state_q == ST_IDLE);
   assign wb.rf_write_enable = wr_en;
   assign wb.rf_addr_rd      = wr_addr;
   assign wb.rf_data_rd      = wr_data;
   assign wb.wb_done         = commit;
   assign wb.wb_fault        = commit && fault_q;

`ifdef WB_FWD_EN
   assign wb.fwd_valid = wr_en;
   assign wb.fwd_rd    = wr_addr;
   assign wb.fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected commits queued at issue, checked on wb_done.
module tb_wb_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(32), .RA_W(5)) bus ();

   wb_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        fault;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic we,
                       input logic fault);
      exp_t e;
      e.rd = rd; e.data = data; e.we = we; e.fault = fault;
      sb.push_back(e);
   endtask

   task automatic drive_idle();
      bus.ex_valid      = 1'b0;
      bus.ex_rd         = 5'($urandom);
      bus.ex_wb_sel     = 2'($urandom);
      bus.ex_alu_result = $urandom;
      bus.ex_pc_plus4   = $urandom;
      bus.ex_funct3     = 3'($urandom);
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = $urandom;
   endtask

   // Commit monitor: pops one expectation per wb_done, otherwise expects a quiet write port.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (bus.wb_done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(bus.wb_done), 32'd0);
            end else begin
               e = sb.pop_front();
               check("wr_en", 32'(bus.rf_write_enable), 32'(e.we));
               check("fault", 32'(bus.wb_fault), 32'(e.fault));
               if (e.we) begin
                  check("wr_addr", 32'(bus.rf_addr_rd), 32'(e.rd));
                  check("wr_data", bus.rf_data_rd, e.data);
               end
               if (e.fault) check("fault_data", bus.rf_data_rd, 32'd0);
`ifdef WB_FWD_EN
               check("fwd_valid", 32'(bus.fwd_valid), 32'(e.we));
               if (e.we) begin
                  check("fwd_rd", 32'(bus.fwd_rd), 32'(e.rd));
                  check("fwd_data", bus.fwd_data, e.data);
               end
`endif
            end
         end else begin
            check("idle_wr_en", 32'(bus.rf_write_enable), 32'd0);
            check("idle_fault", 32'(bus.wb_fault), 32'd0);
`ifdef WB_FWD_EN
            check("idle_fwd", {bus.fwd_valid, 26'(bus.fwd_rd)} | bus.fwd_data, 32'd0);
`endif
         end
      end
   end

   task automatic send_op(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [31:0] exp_data,
                          input logic exp_we);
      @(negedge clk);
      check("ready_pre", 32'(bus.ex_ready), 32'd1);
      bus.ex_valid      = 1'b1;
      bus.ex_rd         = rd;
      bus.ex_wb_sel     = sel;
      bus.ex_alu_result = alu;
      bus.ex_pc_plus4   = pc4;
      push(rd, exp_data, exp_we, 1'b0);
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("ready_commit", 32'(bus.ex_ready), 32'd0);
      check("done_op", 32'(bus.wb_done), 32'd1);
   endtask

   task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] rdata, input int unsigned delay,
                            input logic [31:0] exp_data, input logic exp_we,
                            input logic exp_fault);
      logic [31:0] addr;
      addr      = $urandom;
      addr[1:0] = lo;
      @(negedge clk);
      check("ready_pre", 32'(bus.ex_ready), 32'd1);
      bus.ex_valid      = 1'b1;
      bus.ex_rd         = rd;
      bus.ex_wb_sel     = WB_LOAD;
      bus.ex_alu_result = addr;
      bus.ex_funct3     = f3;
      push(rd, exp_data, exp_we, exp_fault);
      @(posedge clk);
      #1 drive_idle();
      for (int unsigned i = 0; i < delay; i++) begin
         @(negedge clk);
         check("ready_wait", 32'(bus.ex_ready), 32'd0);
         check("done_wait", 32'(bus.wb_done), 32'd0);
      end
      @(negedge clk);
      check("ready_wait", 32'(bus.ex_ready), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("done_load", 32'(bus.wb_done), 32'd1);
      check("ready_commit", 32'(bus.ex_ready), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      #12;
      check("rst_ready", 32'(bus.ex_ready), 32'd1);
      check("rst_addr", 32'(bus.rf_addr_rd), 32'd0);
      check("rst_data", bus.rf_data_rd, 32'd0);
      check("rst_we", 32'(bus.rf_write_enable), 32'd0);
      check("rst_done", 32'(bus.wb_done), 32'd0);
      check("rst_fault", 32'(bus.wb_fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      send_op(5'd5, WB_ALU, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b1);
      send_op(5'd0, WB_ALU, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0);
      send_op(5'd1, WB_PC4, 32'hDEAD_0000, 32'h0000_0100, 32'h0000_0100, 1'b1);
      send_op(5'd7, WB_NONE, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0);

      send_load(5'd3,  F3_LB,  2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80, 1'b1, 1'b0);
      send_load(5'd4,  F3_LBU, 2'd2, 32'h0080_0000, 3, 32'h0000_0080, 1'b1, 1'b0);
      send_load(5'd6,  F3_LB,  2'd3, 32'h7F00_0000, 0, 32'h0000_007F, 1'b1, 1'b0);
      send_load(5'd8,  F3_LH,  2'd2, 32'h8001_0000, 1, 32'hFFFF_8001, 1'b1, 1'b0);
      send_load(5'd9,  F3_LHU, 2'd2, 32'h8001_0000, 0, 32'h0000_8001, 1'b1, 1'b0);
      send_load(5'd10, F3_LH,  2'd1, 32'h00AB_CD00, 2, 32'hFFFF_ABCD, 1'b1, 1'b0);
      send_load(5'd11, F3_LW,  2'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      send_load(5'd0,  F3_LW,  2'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
      send_load(5'd12, F3_LW,  2'd1, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b1);
      send_load(5'd13, F3_LH,  2'd3, 32'h3333_4444, 1, 32'h0, 1'b0, 1'b1);
      send_load(5'd14, 3'b011, 2'd0, 32'h5555_6666, 0, 32'h0, 1'b0, 1'b1);

      // ex_valid held across two instructions: second accepted only once IDLE returns.
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd20; bus.ex_wb_sel = WB_ALU;
      bus.ex_alu_result = 32'h0000_0AAA;
      push(5'd20, 32'h0000_0AAA, 1'b1, 1'b0);
      @(posedge clk);
      #1 bus.ex_rd = 5'd21; bus.ex_alu_result = 32'h0000_0BBB;
      push(5'd21, 32'h0000_0BBB, 1'b1, 1'b0);
      @(negedge clk);
      check("b2b_ready_commit", 32'(bus.ex_ready), 32'd0);
      @(negedge clk);
      check("b2b_ready_idle", 32'(bus.ex_ready), 32'd1);
      check("b2b_no_done", 32'(bus.wb_done), 32'd0);
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("b2b_done2", 32'(bus.wb_done), 32'd1);

      // Stray read response while IDLE.
      @(negedge clk);
      bus.mem_rvalid = 1'b1;
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("stray_ready", 32'(bus.ex_ready), 32'd1);
      check("stray_done", 32'(bus.wb_done), 32'd0);

      // Reset while waiting for a load: pending write dropped, late rvalid ignored.
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd15; bus.ex_wb_sel = WB_LOAD;
      bus.ex_alu_result = 32'h0000_1000; bus.ex_funct3 = F3_LW;
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("rstw_ready_wait", 32'(bus.ex_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rstw_ready", 32'(bus.ex_ready), 32'd1);
      check("rstw_we", 32'(bus.rf_write_enable), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777_8888;
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("rstw_done", 32'(bus.wb_done), 32'd0);
      check("rstw_we2", 32'(bus.rf_write_enable), 32'd0);
      check("rstw_ready2", 32'(bus.ex_ready), 32'd1);

      send_op(5'd2, WB_ALU, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b1);

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the unpipelined RISC-V core; sits directly upstream of the register file and drives its write port (`addr_rd`, `data_rd`, `write_enable`). Accepts one retiring instruction at a time from execute, waits for the load response from data memory when needed, aligns and sign/zero-extends load data, and issues exactly one registered write per instruction. Also produces a retire pulse and a fault flag for the control FSM.

## Interface

Parameters:
- `XLEN`, 32, datapath width
- `RA_W`, 5, register address width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  execute presents an instruction
- `ex_ready`  out  1  stage can accept (IDLE only)
- `ex_rd`  in  RA_W  destination register
- `ex_wb_sel`  in  2  00 NONE, 01 ALU, 10 LOAD, 11 PC4
- `ex_alu_result`  in  XLEN  ALU result; for loads, effective address
- `ex_pc_plus4`  in  XLEN  link value for JAL/JALR
- `ex_funct3`  in  3  load type
- `mem_rvalid`  in  1  data memory read response valid
- `mem_rdata`  in  XLEN  aligned 32-bit word containing the load
- `rf_addr_rd`  out  RA_W  to register file `addr_rd`
- `rf_data_rd`  out  XLEN  to register file `data_rd`
- `rf_write_enable`  out  1  to register file `write_enable`
- `wb_done`  out  1  one-cycle retire pulse
- `wb_fault`  out  1  one-cycle pulse with `wb_done` on misaligned/illegal load

## Operation

- FSM states IDLE, WAIT_LOAD, COMMIT; reset state IDLE.
- IDLE: `ex_ready`=1. Handshake = `ex_valid & ex_ready`. On accept, latch rd, wb_sel, funct3, addr_lo = `ex_alu_result[1:0]`.
  - wb_sel LOAD -> WAIT_LOAD.
  - ALU/PC4 -> COMMIT with data latched (ALU result or pc_plus4).
  - NONE -> COMMIT, no write.
- WAIT_LOAD: `ex_ready`=0. On `mem_rvalid`, latch aligned data from `mem_rdata` -> COMMIT. Otherwise hold indefinitely.
- COMMIT: `rf_write_enable`=1 iff wb_sel != NONE, rd != 0, no fault. `wb_done`=1. `ex_ready`=0. Next state IDLE.
- Load alignment: byte = `mem_rdata >> (8*addr_lo)`.
  - LB 000 sign-extend [7:0]; LBU 100 zero-extend [7:0].
  - LH 001 sign-extend [15:0]; LHU 101 zero-extend [15:0].
  - LW 010 full word.
- Faults: halfword with addr_lo==3; word with addr_lo!=0; funct3 011/110/111. Fault -> `wb_fault`=1 in COMMIT, write suppressed, `rf_data_rd`=0.
- `mem_rvalid` outside WAIT_LOAD is ignored.
- `ex_valid` while `ex_ready`=0 is ignored; upstream holds it.

## Timing

- All outputs registered or decoded from registered state only; no comb path from inputs to outputs except `ex_ready` (state-only).
- Reset values: `ex_ready`=1, `rf_addr_rd`=0, `rf_data_rd`=0, `rf_write_enable`=0, `wb_done`=0, `wb_fault`=0.
- Non-load: accept at edge N -> COMMIT for cycle N+1 -> register file captures at end of N+1 -> IDLE, `ex_ready`=1 in cycle N+2.
- Load: `mem_rvalid` sampled at edge M -> COMMIT in M+1. Earliest case: accept and rvalid on consecutive edges = 2-cycle latency.
- Throughput: at most one instruction per 2 cycles.
- Reset asserted mid-WAIT_LOAD or mid-COMMIT: immediate return to IDLE, outputs to reset values, pending write dropped, later stray `mem_rvalid` ignored.

## Configuration

- `WB_FWD_EN` defined: adds outputs `fwd_valid` (1), `fwd_rd` (RA_W), `fwd_data` (XLEN).
  - Equal to `rf_write_enable`/`rf_addr_rd`/`rf_data_rd` in COMMIT; zero otherwise, including reset.
  - Lets decode bypass the value being written this cycle, because register file reads are combinational and writes land at the edge.
- `WB_FWD_EN` undefined: ports absent, no logic.

## Structure

- Shared package `riscv_pkg`: wb_sel encodings (`WB_NONE`, `WB_ALU`, `WB_LOAD`, `WB_PC4`), load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`), and the wb state enum.
- One sub-module `load_align`: combinational; inputs rdata, funct3, addr_lo; outputs data, fault. Instantiated once.

## Test plan

- ALU write: accept rd=5, sel ALU, result 0x1234_5678 -> next cycle `rf_write_enable`=1, `rf_addr_rd`=5, `rf_data_rd`=0x1234_5678, `wb_done`=1; `ex_ready`=1 the cycle after.
- rd=0: sel ALU, rd=0, result 0xFFFF_FFFF -> `wb_done`=1, `rf_write_enable`=0.
- LB: addr_lo=2, rdata=0x0080_0000, 3-cycle rvalid delay -> `ex_ready`=0 throughout; COMMIT with data 0xFFFF_FF80. Same case with LBU -> 0x0000_0080.
- Fault: LW with addr_lo=1 -> `wb_fault`=1, `wb_done`=1, no write. LH with addr_lo=3 -> same.
- Reset in WAIT_LOAD: `rst_n` low for 1 cycle, then `mem_rvalid` pulse -> no write, no `wb_done`, `ex_ready`=1.
- PC4 with `WB_FWD_EN`: pc_plus4=0x100 to rd=1 -> `fwd_valid`=1, `fwd_rd`=1, `fwd_data`=0x100 in the same cycle as the write; all 0 otherwise.
